// File: rtl/instr_encoder_writer.sv
// Encodes MIPS-style R/I/J field bundles into 32-bit words and streams them to instruction memory.
// Optional macro ENC_ILLEGAL_CHECK_EN: reserved in_type=3 bundles are dropped and flagged on err.
module instr_encoder_writer #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] count,
  output logic        done
`ifdef ENC_ILLEGAL_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [1:0] T_R = 2'd0;
  localparam logic [1:0] T_J = 2'd2;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [1:0]  state;
  logic [16:0] count_inc;
  logic        room;
  logic        ack_fire;
  logic        accept;
  logic        illegal;
  logic [31:0] enc_word;

  // mem_we doubles as the pending flag of the single write register.
  assign count_inc = {1'b0, count} + 17'd1;
  assign room      = (count_inc < DEPTH_W);
  assign ack_fire  = mem_we & mem_ack;
  assign in_ready  = (state == S_RUN) & (~mem_we | (mem_ack & room));
  assign accept    = in_valid & in_ready;
  assign done      = (state == S_FULL);

`ifdef ENC_ILLEGAL_CHECK_EN
  assign illegal = (in_type == 2'd3);
`else
  assign illegal = 1'b0;
`endif

  // NOTE: assign a default before the case so no path leaves enc_word unassigned (no latch).
  always_comb begin
    enc_word = {in_op, in_rs, in_rt, in_imm};
    case (in_type)
      T_R:     enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      T_J:     enc_word = {5'b00001, in_op[0], in_target};
      default: enc_word = {in_op, in_rs, in_rt, in_imm};
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      count     <= 16'd0;
    end else if (start) begin
      // start overrides any handshake or ack landing in the same cycle
      state    <= S_RUN;
      mem_we   <= 1'b0;
      mem_addr <= base_addr;
      count    <= 16'd0;
    end else begin
      if (ack_fire) begin
        mem_addr <= mem_addr + 32'd4;
        count    <= count + 16'd1;
      end
      if (accept && !illegal) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
      end else if (ack_fire) begin
        mem_we <= 1'b0;
      end
      // An ack with no room left can never coincide with an accept.
      if (ack_fire && !room && state == S_RUN) begin
        state <= S_FULL;
      end
    end
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (accept && illegal) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Self-checking bench for instr_encoder_writer (DEPTH=4): directed scenarios plus a randomized
// run scored against a transaction-level queue model.
module tb_instr_encoder_writer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_type = 2'd0;
  logic [5:0]  in_op = 6'd0;
  logic [4:0]  in_rs = 5'd0;
  logic [4:0]  in_rt = 5'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic [5:0]  in_funct = 6'd0;
  logic [15:0] in_imm = 16'd0;
  logic [25:0] in_target = 26'd0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] count;
  logic        done;
`ifdef ENC_ILLEGAL_CHECK_EN
  logic        err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .done(done)
`ifdef ENC_ILLEGAL_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Reference encoding computed from the field weights of the 32-bit word.
  function automatic logic [31:0] ref_word(input bundle_t b);
    int unsigned w;
    case (b.t)
      2'd0: w = b.rs * 32'h200000 + b.rt * 32'h10000 + b.rd * 32'h800
              + b.shamt * 32'h40 + b.funct;
      2'd2: w = 32'h08000000 + b.op[0] * 32'h04000000 + b.target;
      default: w = b.op * 32'h04000000 + b.rs * 32'h200000 + b.rt * 32'h10000 + b.imm;
    endcase
    return w;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.t      = 2'($urandom_range(0, 3));
    b.op     = 6'($urandom);
    b.rs     = 5'($urandom);
    b.rt     = 5'($urandom);
    b.rd     = 5'($urandom);
    b.shamt  = 5'($urandom);
    b.funct  = 6'($urandom);
    b.imm    = 16'($urandom);
    b.target = 26'($urandom);
    return b;
  endfunction

  task automatic apply(input bundle_t b);
    in_type = b.t; in_op = b.op; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
    in_shamt = b.shamt; in_funct = b.funct; in_imm = b.imm; in_target = b.target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    bundle_t b;
    rst = 1'b1;
    repeat (2) tick();
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
`ifdef ENC_ILLEGAL_CHECK_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", err); end
`endif
    @(negedge clk);
    rst = 1'b0;
    b = rand_bundle();
    apply(b);
    in_valid = 1'b1;
    repeat (2) tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got=%0b exp=0", in_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_mem_we got=%0b exp=0", mem_we); end
    in_valid = 1'b0;
  endtask

  task automatic test_encodings();
    bundle_t b;
    do_start(32'h00400000);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL run_in_ready got=%0b exp=1", in_ready); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL run_count got=%0d exp=0", count); end
    // R: add $3,$1,$2 with in_op as noise
    b = rand_bundle();
    b.t = 2'd0; b.rs = 5'd1; b.rt = 5'd2; b.rd = 5'd3; b.shamt = 5'd0; b.funct = 6'h20;
    apply(b); in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL r_mem_we got=%0b exp=1", mem_we); end
    n_tests++; if (mem_wdata !== 32'h00221820) begin n_fail++; $display("FAIL r_word got=%h exp=00221820", mem_wdata); end
    n_tests++; if (mem_addr !== 32'h00400000) begin n_fail++; $display("FAIL r_addr got=%h exp=00400000", mem_addr); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    n_tests++; if (count !== 16'd1) begin n_fail++; $display("FAIL r_count got=%0d exp=1", count); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL r_we_after_ack got=%0b exp=0", mem_we); end
    // JAL
    b = rand_bundle();
    b.t = 2'd2; b.op = 6'b101011; b.target = 26'h0100000;
    apply(b); in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_tests++; if (mem_wdata !== 32'h0C100000) begin n_fail++; $display("FAIL j_word got=%h exp=0C100000", mem_wdata); end
    n_tests++; if (mem_addr !== 32'h00400004) begin n_fail++; $display("FAIL j_addr got=%h exp=00400004", mem_addr); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    // lw $8,-4($29)
    b = rand_bundle();
    b.t = 2'd1; b.op = 6'h23; b.rs = 5'd29; b.rt = 5'd8; b.imm = 16'hFFFC;
    apply(b); in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_tests++; if (mem_wdata !== 32'h8FA8FFFC) begin n_fail++; $display("FAIL i_word got=%h exp=8FA8FFFC", mem_wdata); end
    n_tests++; if (mem_addr !== 32'h00400008) begin n_fail++; $display("FAIL i_addr got=%h exp=00400008", mem_addr); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    n_tests++; if (count !== 16'd3) begin n_fail++; $display("FAIL i_count got=%0d exp=3", count); end
  endtask

  task automatic test_stall();
    bundle_t a;
    bundle_t b;
    a = rand_bundle(); a.t = 2'd0;
    b = rand_bundle(); b.t = 2'd1;
    do_start(32'h00001000);
    apply(a); in_valid = 1'b1; tick();
    apply(b); mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL stall_we[%0d] got=%0b exp=1", i, mem_we); end
      n_tests++; if (mem_wdata !== ref_word(a)) begin n_fail++; $display("FAIL stall_word[%0d] got=%h exp=%h", i, mem_wdata, ref_word(a)); end
      n_tests++; if (mem_addr !== 32'h00001000) begin n_fail++; $display("FAIL stall_addr[%0d] got=%h exp=00001000", i, mem_addr); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, in_ready); end
      @(posedge clk);
    end
    #1;
    mem_ack = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b0;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we got=%0b exp=1", mem_we); end
    n_tests++; if (mem_wdata !== ref_word(b)) begin n_fail++; $display("FAIL b2b_word got=%h exp=%h", mem_wdata, ref_word(b)); end
    n_tests++; if (mem_addr !== 32'h00001004) begin n_fail++; $display("FAIL b2b_addr got=%h exp=00001004", mem_addr); end
    n_tests++; if (count !== 16'd1) begin n_fail++; $display("FAIL b2b_count got=%0d exp=1", count); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    n_tests++; if (count !== 16'd2) begin n_fail++; $display("FAIL b2b_count2 got=%0d exp=2", count); end
  endtask

  task automatic test_full();
    bundle_t bs[5];
    int idx;
    int writes;
    bit hs;
    for (int i = 0; i < 5; i++) bs[i] = rand_bundle();
    for (int i = 0; i < 5; i++) if (bs[i].t == 2'd3) bs[i].t = 2'd1;
    do_start(32'h00002000);
    idx = 0; writes = 0;
    apply(bs[0]); in_valid = 1'b1; mem_ack = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (mem_we && mem_ack && writes < 5) begin
        n_tests++; if (mem_wdata !== ref_word(bs[writes])) begin n_fail++; $display("FAIL full_word[%0d] got=%h exp=%h", writes, mem_wdata, ref_word(bs[writes])); end
        n_tests++; if (mem_addr !== 32'h00002000 + 32'(writes) * 4) begin n_fail++; $display("FAIL full_addr[%0d] got=%h", writes, mem_addr); end
        writes++;
      end
      hs = in_valid && in_ready && idx < 5;
      @(posedge clk); #1;
      if (hs) idx++;
      if (idx < 5) apply(bs[idx]);
    end
    n_tests++; if (writes !== 4) begin n_fail++; $display("FAIL full_writes got=%0d exp=4", writes); end
    n_tests++; if (idx !== 4) begin n_fail++; $display("FAIL full_accepts got=%0d exp=4", idx); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done got=%0b exp=1", done); end
    n_tests++; if (count !== 16'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", in_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL full_we got=%0b exp=0", mem_we); end
    mem_ack = 1'b0;
    do_start(32'h00003000);
    in_valid = 1'b0;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done got=%0b exp=0", done); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL restart_count got=%0d exp=0", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready got=%0b exp=1", in_ready); end
    n_tests++; if (mem_addr !== 32'h00003000) begin n_fail++; $display("FAIL restart_addr got=%h exp=00003000", mem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    bundle_t a;
    bundle_t b;
    a = rand_bundle(); a.t = 2'd0;
    b = rand_bundle(); b.t = 2'd2;
    do_start(32'hFFFFFFFC);
    apply(a); in_valid = 1'b1; tick();
    n_tests++; if (mem_addr !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_addr0 got=%h exp=FFFFFFFC", mem_addr); end
    n_tests++; if (mem_wdata !== ref_word(a)) begin n_fail++; $display("FAIL wrap_word0 got=%h exp=%h", mem_wdata, ref_word(a)); end
    apply(b); mem_ack = 1'b1; tick();
    in_valid = 1'b0; mem_ack = 1'b0;
    n_tests++; if (mem_addr !== 32'h00000000) begin n_fail++; $display("FAIL wrap_addr1 got=%h exp=00000000", mem_addr); end
    n_tests++; if (mem_wdata !== ref_word(b)) begin n_fail++; $display("FAIL wrap_word1 got=%h exp=%h", mem_wdata, ref_word(b)); end
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wrap_we got=%0b exp=1", mem_we); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL async_rst_we got=%0b exp=0", mem_we); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL async_rst_count got=%0d exp=0", count); end
    n_tests++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL async_rst_addr got=%h exp=0", mem_addr); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we got=%0b exp=0", mem_we); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=0", count); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready got=%0b exp=0", in_ready); end
  endtask

  task automatic test_reserved_type();
    bundle_t x;
    bundle_t r;
    x = rand_bundle(); x.t = 2'd3;
    r = rand_bundle(); r.t = 2'd0;
    do_start(32'h00005000);
    apply(x); in_valid = 1'b1; tick(); in_valid = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rsv_we got=%0b exp=0", mem_we); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got=%0b exp=1", err); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_ready got=%0b exp=1", in_ready); end
    apply(r); in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_tests++; if (mem_wdata !== ref_word(r)) begin n_fail++; $display("FAIL rsv_next_word got=%h exp=%h", mem_wdata, ref_word(r)); end
    n_tests++; if (mem_addr !== 32'h00005000) begin n_fail++; $display("FAIL rsv_next_addr got=%h exp=00005000", mem_addr); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    n_tests++; if (count !== 16'd1) begin n_fail++; $display("FAIL rsv_count got=%0d exp=1", count); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err_sticky got=%0b exp=1", err); end
    do_start(32'h00006000);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rsv_err_clear got=%0b exp=0", err); end
`else
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rsv_we got=%0b exp=1", mem_we); end
    n_tests++; if (mem_wdata !== {x.op, x.rs, x.rt, x.imm}) begin n_fail++; $display("FAIL rsv_word got=%h exp=%h", mem_wdata, {x.op, x.rs, x.rt, x.imm}); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    n_tests++; if (count !== 16'd1) begin n_fail++; $display("FAIL rsv_count got=%0d exp=1", count); end
`endif
  endtask

  task automatic test_random();
    bundle_t b;
    bit s, exp_ready, ack_f, in_f, m_run, m_full, m_err;
    int m_count;
    logic [31:0] m_base, base;
    logic [31:0] q_addr[$];
    logic [31:0] q_word[$];
    m_run = 0; m_full = 0; m_err = 0; m_count = 0; m_base = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      s = (cyc == 0) || ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) base = 32'hFFFFFFF0 + 32'($urandom_range(0, 3)) * 4;
      else base = $urandom & 32'hFFFFFFFC;
      start = s; base_addr = base;
      b = rand_bundle(); apply(b);
      in_valid = ($urandom_range(0, 9) < 7);
      mem_ack  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_ready = m_run && (q_addr.size() == 0 || (mem_ack && m_count + 1 < DEPTH));
      if (cyc > 0) begin
        n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d got=%0b exp=%0b", cyc, in_ready, exp_ready); end
        n_tests++; if (mem_we !== (q_addr.size() != 0)) begin n_fail++; $display("FAIL rnd_we@%0d got=%0b exp=%0b", cyc, mem_we, q_addr.size() != 0); end
        if (q_addr.size() != 0) begin
          n_tests++; if (mem_addr !== q_addr[0]) begin n_fail++; $display("FAIL rnd_addr@%0d got=%h exp=%h", cyc, mem_addr, q_addr[0]); end
          n_tests++; if (mem_wdata !== q_word[0]) begin n_fail++; $display("FAIL rnd_word@%0d got=%h exp=%h", cyc, mem_wdata, q_word[0]); end
        end
        n_tests++; if (count !== 16'(m_count)) begin n_fail++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", cyc, count, m_count); end
        n_tests++; if (done !== m_full) begin n_fail++; $display("FAIL rnd_done@%0d got=%0b exp=%0b", cyc, done, m_full); end
`ifdef ENC_ILLEGAL_CHECK_EN
        n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d got=%0b exp=%0b", cyc, err, m_err); end
`endif
      end
      if (s) begin
        q_addr.delete(); q_word.delete();
        m_count = 0; m_base = base; m_run = 1; m_full = 0; m_err = 0;
      end else begin
        ack_f = mem_ack && q_addr.size() != 0;
        in_f  = in_valid && exp_ready;
        if (ack_f) begin
          void'(q_addr.pop_front()); void'(q_word.pop_front());
          m_count++;
        end
        if (in_f) begin
`ifdef ENC_ILLEGAL_CHECK_EN
          if (b.t == 2'd3) m_err = 1;
          else begin
            q_addr.push_back(m_base + 32'(m_count) * 4);
            q_word.push_back(ref_word(b));
          end
`else
          q_addr.push_back(m_base + 32'(m_count) * 4);
          q_word.push_back(ref_word(b));
`endif
        end
        if (ack_f && !in_f && m_count == DEPTH) begin
          m_run = 0; m_full = 1;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_stall();
    test_full();
    test_wrap_and_reset();
    test_reserved_type();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_writer.md
INSTR_ENCODER_WRITER -- requirements
Module: instr_encoder_writer

Interface
REQ-001 Parameter DEPTH, default 256, maximum number of words written per session (1..65535).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  opens a new session at base_addr.
REQ-005 base_addr  input  32  byte address of the first word in the session.
REQ-006 in_valid  input  1  field bundle valid.
REQ-007 in_ready  output  1  bundle accepted when in_valid & in_ready.
REQ-008 in_type  input  2  0=R (SPECIAL), 1=I, 2=J, 3=reserved.
REQ-009 in_op  input  6; in_rs, in_rt, in_rd, in_shamt  input  5 each; in_funct  input  6; in_imm  input  16; in_target  input  26  instruction fields.
REQ-010 mem_we  output  1  write request to instruction memory.
REQ-011 mem_addr  output  32  write byte address.
REQ-012 mem_wdata  output  32  encoded instruction word.
REQ-013 mem_ack  input  1  memory accepted the write this cycle.
REQ-014 count  output  16  words completed (acked) this session.
REQ-015 done  output  1  high in FULL state.
REQ-016 err  output  1  sticky reserved-type flag (present only with ENC_ILLEGAL_CHECK_EN).

Function
REQ-017 States IDLE, RUN, FULL; reset enters IDLE.
REQ-018 start in any state: addr<=base_addr, count<=0, pending write dropped (mem_we<=0), state<=RUN; start has priority over every other event that cycle, including a coincident handshake or mem_ack.
REQ-019 R encoding: {6'b000000, rs, rt, rd, shamt, funct}; in_op ignored.
REQ-020 I encoding: {op, rs, rt, imm}.
REQ-021 J encoding: {5'b00001, in_op[0], target} (J when in_op[0]=0, JAL when 1); other fields ignored.
REQ-022 Single pending-write register; handshake in cycle N drives mem_we=1 with encoded word at mem_addr from cycle N+1.
REQ-023 mem_we, mem_addr, mem_wdata held stable until the cycle mem_ack=1; mem_ack while mem_we=0 ignored.
REQ-024 On ack: addr<=addr+4 (wraps modulo 2^32), count<=count+1.
REQ-025 in_ready = (state==RUN) & (!pending | (mem_ack & count+1<DEPTH)); back-to-back accept on ack cycle gives one word per cycle throughput.
REQ-026 Ack bringing count to DEPTH with no new accept: state<=FULL, in_ready=0, done=1; FULL left only via start.
REQ-027 in_ready=0 in IDLE and FULL; in_valid there has no effect.

Reset
REQ-028 rst asserted: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err=0, pending cleared, immediately and asynchronously.
REQ-029 rst mid-write abandons the write; no ack is awaited after release.

Configuration
REQ-030 Macro ENC_ILLEGAL_CHECK_EN defined: in_type=3 bundle is accepted but not written (no mem_we, count unchanged) and sets err until rst or start.
REQ-031 Macro undefined: in_type=3 encoded as I-type; err port absent.

Verification
REQ-032 rst, start base=0x00400000, R rs=1 rt=2 rd=3 shamt=0 funct=0x20, ack next cycle -> mem_wdata=0x00221820, mem_addr=0x00400000, count=1.
REQ-033 J op[0]=1 target=0x0100000 -> mem_wdata=0x0C100000; I op=0x23 rs=29 rt=8 imm=0xFFFC -> 0x8FA8FFFC at addr+4.
REQ-034 mem_ack held low 5 cycles -> mem_we and word stable, in_ready=0 throughout; ack -> in_ready same cycle, next word written with no gap.
REQ-035 DEPTH=4, stream 5 bundles with ack every cycle -> 4 writes, done=1, 5th bundle never accepted; start -> RUN, count=0.
REQ-036 base=0xFFFFFFFC, two writes -> second mem_addr=0x00000000; rst asserted while mem_we=1 -> mem_we=0 same cycle, state IDLE.
REQ-037 ENC_ILLEGAL_CHECK_EN defined, in_type=3 -> no mem_we, err=1 until start.
